// File: rtl/crt_pkg.sv
// crt_pkg: shared definitions for the sequential CRT reconstructor.
//   - crt_state_e  : controller state encoding
//   - CRT_SLICE    : channel slice of a packed moduli/residue bus
//   - crt_out_w_ok : result-width sanity check used at elaboration
`ifndef CRT_PKG_SV
`define CRT_PKG_SV

// Channel idx of a bus packing w-bit fields, channel 0 in the LSBs.
`define CRT_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package crt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        RED_X  = 3'd2,
        RED_M  = 3'd3,
        SEARCH = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } crt_state_e;

    // The running modulus product must fit in the result register.
    function automatic bit crt_out_w_ok(input int out_w, input int num_ch, input int res_w);
        return out_w >= num_ch * res_w;
    endfunction

endpackage

`endif

// File: rtl/crt_mod_reduce.sv
// crt_mod_reduce: restoring remainder of an OUT_W-bit dividend by a
// RES_W-bit non-zero divisor, one dividend bit per cycle, MSB first.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          load dividend/divisor and begin (takes priority)
//   dividend       OUT_W-bit value to reduce
//   divisor        RES_W-bit modulus, must be non-zero
//   busy           reduction in progress
//   done           high during the final busy cycle; remainder is valid then
//   remainder      dividend mod divisor (valid while done=1)
// The remainder is presented combinationally in the last cycle so the caller
// can capture it and restart in the same edge: exactly OUT_W cycles per job.
module crt_mod_reduce
    import crt_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int RES_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OUT_W-1:0] dividend,
    input  logic [RES_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] remainder
);

    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] div_q, div_d;
    logic [RES_W-1:0] dsr_q, dsr_d;
    logic [RES_W-1:0] rem_q, rem_d;

    logic [RES_W:0]   trial;
    logic [RES_W-1:0] rem_next;
    logic             last;

    // Partial remainder is always < divisor, so one trial subtract suffices.
    always_comb begin
        trial    = {rem_q, div_q[OUT_W-1]};
        rem_next = (trial >= {1'b0, dsr_q}) ? RES_W'(trial - {1'b0, dsr_q})
                                            : trial[RES_W-1:0];
        last     = busy_q && (cnt_q == LAST_BIT);
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            div_d  = dividend;
            dsr_d  = divisor;
            rem_d  = '0;
        end else if (busy_q) begin
            rem_d = rem_next;
            div_d = {div_q[OUT_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            div_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = last;
    assign remainder = rem_next;

endmodule

// File: rtl/crt_reconstruct_seq.sv
// crt_reconstruct_seq: sequential Chinese Remainder Theorem reconstructor.
// Rebuilds X in [0, prod(m)) from NUM_CH moduli/residue pairs by incremental
// mixed-radix search, flagging malformed or inconsistent inputs.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready only while idle
//   moduli, residues      NUM_CH packed RES_W-bit fields, channel 0 in LSBs
//   out_valid / out_ready output handshake; result/error held until accepted
//   result                reconstructed X, 0 when error=1
//   error                 zero modulus, residue >= modulus, or no solution
module crt_reconstruct_seq
    import crt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int RES_W  = 4,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*RES_W-1:0] moduli,
    input  logic [NUM_CH*RES_W-1:0] residues,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        result,
    output logic                    error
);

    localparam int CH_W  = NUM_CH * RES_W;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    if (!crt_out_w_ok(OUT_W, NUM_CH, RES_W)) begin : g_out_w_chk
        $error("crt_reconstruct_seq: OUT_W must be >= NUM_CH*RES_W");
    end

    crt_state_e       state_q, state_d;
    logic [CH_W-1:0]  mod_q, mod_d;
    logic [CH_W-1:0]  res_q, res_d;
    logic [OUT_W-1:0] x_q, x_d;
    logic [OUT_W-1:0] macc_q, macc_d;   // product of moduli already folded in
    logic [IDX_W-1:0] i_q, i_d;
    logic [RES_W-1:0] k_q, k_d;
    logic [RES_W-1:0] xr_q, xr_d;       // X mod m_i, tracked incrementally
    logic [RES_W-1:0] mr_q, mr_d;       // M mod m_i
    logic             err_q, err_d;

    logic [RES_W-1:0] cur_m, cur_r;
    logic [RES_W:0]   sum_xm;
    logic             bad_in;
    logic [IDX_W-1:0] red_idx;
    logic             red_start;
    logic [OUT_W-1:0] red_dividend;
    logic [RES_W-1:0] red_divisor;
    logic             red_busy, red_done, red_fin;
    logic [RES_W-1:0] red_rem;

    crt_mod_reduce #(
        .OUT_W (OUT_W),
        .RES_W (RES_W)
    ) u_mod_reduce (
        .clk       (clk),
        .reset     (reset),
        .start     (red_start),
        .dividend  (red_dividend),
        .divisor   (red_divisor),
        .busy      (red_busy),
        .done      (red_done),
        .remainder (red_rem)
    );

    assign red_fin = red_busy & red_done;

    always_comb begin
        cur_m  = `CRT_SLICE(mod_q, int'(i_q), RES_W);
        cur_r  = `CRT_SLICE(res_q, int'(i_q), RES_W);
        sum_xm = {1'b0, xr_q} + {1'b0, mr_q};
        bad_in = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((`CRT_SLICE(mod_q, c, RES_W) == '0) ||
                (`CRT_SLICE(res_q, c, RES_W) >= `CRT_SLICE(mod_q, c, RES_W))) begin
                bad_in = 1'b1;
            end
        end
        // A reduction started from CHECK or NEXT targets the channel about
        // to be processed, which i_q does not point at yet.
        red_idx     = (state_q == CHECK) ? IDX_W'(1) : (i_q + IDX_W'(1));
        red_divisor = (state_q == RED_X || state_q == RED_M) ? cur_m
                                                             : `CRT_SLICE(mod_q, int'(red_idx), RES_W);
    end

    always_comb begin
        state_d      = state_q;
        mod_d        = mod_q;
        res_d        = res_q;
        x_d          = x_q;
        macc_d       = macc_q;
        i_d          = i_q;
        k_d          = k_q;
        xr_d         = xr_q;
        mr_d         = mr_q;
        err_d        = err_q;
        red_start    = 1'b0;
        red_dividend = x_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mod_d   = moduli;
                    res_d   = residues;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (bad_in) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d    = OUT_W'(res_q[RES_W-1:0]);
                    macc_d = OUT_W'(mod_q[RES_W-1:0]);
                    i_d    = IDX_W'(1);
                    if (NUM_CH == 1) begin
                        state_d = DONE;
                    end else begin
                        red_start    = 1'b1;
                        red_dividend = OUT_W'(res_q[RES_W-1:0]);
                        state_d      = RED_X;
                    end
                end
            end

            RED_X: begin
                if (red_fin) begin
                    xr_d         = red_rem;
                    red_start    = 1'b1;
                    red_dividend = macc_q;
                    state_d      = RED_M;
                end
            end

            RED_M: begin
                if (red_fin) begin
                    mr_d    = red_rem;
                    k_d     = '0;
                    state_d = SEARCH;
                end
            end

            SEARCH: begin
                if (xr_q == cur_r) begin
                    state_d = NEXT;
                end else if (k_q == (cur_m - RES_W'(1))) begin
                    // Every step X+k*M tried without a match: moduli share
                    // a factor that makes the residues inconsistent.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d  = x_q + macc_q;
                    xr_d = (sum_xm >= {1'b0, cur_m}) ? RES_W'(sum_xm - {1'b0, cur_m})
                                                     : sum_xm[RES_W-1:0];
                    k_d  = k_q + RES_W'(1);
                end
            end

            NEXT: begin
                // Product of all moduli is < 2^(NUM_CH*RES_W) <= 2^OUT_W.
                macc_d = macc_q * OUT_W'(cur_m);
                i_d    = i_q + IDX_W'(1);
                if (i_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    red_start    = 1'b1;
                    red_dividend = x_q;
                    state_d      = RED_X;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mod_q   <= '0;
            res_q   <= '0;
            x_q     <= '0;
            macc_q  <= '0;
            i_q     <= '0;
            k_q     <= '0;
            xr_q    <= '0;
            mr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            res_q   <= res_d;
            x_q     <= x_d;
            macc_q  <= macc_d;
            i_q     <= i_d;
            k_q     <= k_d;
            xr_q    <= xr_d;
            mr_q    <= mr_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign error     = out_valid & err_q;
    assign result    = (out_valid && !err_q) ? x_q : '0;

endmodule
